// File: rtl/vga_timing_if.sv
// -----------------------------------------------------------------------------
// vga_timing_if
//   Raster timing bundle from vga_timing to the character painter and the
//   DAC/connector. The block free-runs, so there is no handshake, only
//   decoded timing that downstream logic samples every clk.
//
//   pix_tick     one-clk strobe per pixel period
//   horzCoord    visible column, 0 outside the active area
//   vertCoord    visible row, 0 outside the active area
//   visible      counters inside the active area (never delayed)
//   hsync_n      horizontal sync, active low
//   vsync_n      vertical sync, active low
//   blank_n      low outside the active area
//   frame_start  one-clk pulse on the first cycle of pixel (0,0)
//
//   master : timing generator (drives everything)
//   slave  : painter / DAC side (samples everything)
// -----------------------------------------------------------------------------
interface vga_timing_if;
   logic       pix_tick;
   logic [9:0] horzCoord;
   logic [9:0] vertCoord;
   logic       visible;
   logic       hsync_n;
   logic       vsync_n;
   logic       blank_n;
   logic       frame_start;

   modport master (
      output pix_tick, horzCoord, vertCoord, visible,
             hsync_n, vsync_n, blank_n, frame_start
   );

   modport slave (
      input  pix_tick, horzCoord, vertCoord, visible,
             hsync_n, vsync_n, blank_n, frame_start
   );
endinterface : vga_timing_if

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//   640x480@60 VGA raster generator. A clock divider produces one pix_tick
//   every CLK_DIV clk cycles; horizontal and vertical counters advance on
//   that tick. Coordinates, visible, sync and blank are decoded from the
//   registered counters so they change only on clk edges.
//
//   Ports
//     clk   in   system clock, the only clock
//     rst   in   synchronous, active-high reset
//     vga   master modport of vga_timing_if (see that file for the signals)
//
//   Compile-time option
//     VGA_SYNC_ALIGN_EN  when defined, hsync_n/vsync_n/blank_n pass through a
//                        PIPE_DELAY-stage shift register so they line up with
//                        the painter's pipelined pixel output. Coordinates,
//                        visible and frame_start are never delayed. When not
//                        defined, sync/blank are decoded directly and
//                        PIPE_DELAY is ignored.
// -----------------------------------------------------------------------------
module vga_timing #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned PIPE_DELAY = 4
) (
   input  logic         clk,
   input  logic         rst,
   vga_timing_if.master vga
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [9:0]       h_cnt_q, h_cnt_d;
   logic [9:0]       v_cnt_q, v_cnt_d;
   logic             frame_start_q, frame_start_d;

   logic             pix_tick;
   logic             visible;
   logic             hsync_raw_n;
   logic             vsync_raw_n;

   // NOTE: every signal assigned here gets a value on every path (defaults
   // first), so no latch can be inferred.
   always_comb begin
      pix_tick  = (div_cnt_q == DIV_LAST);
      div_cnt_d = pix_tick ? '0 : div_cnt_q + DIV_W'(1);

      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pix_tick) begin
         if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
         end else begin
            h_cnt_d = h_cnt_q + 10'd1;
         end
      end

      // Registered so the pulse lands on the first cycle of pixel (0,0).
      frame_start_d = pix_tick && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

      visible     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hsync_raw_n = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_END));
      vsync_raw_n = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_END));
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample their _d values from the same edge.
   // A reset edge also clears frame_start_q, which cancels a pulse that the
   // wrap tick had already scheduled.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q     <= '0;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         frame_start_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         frame_start_q <= frame_start_d;
      end
   end

   // Coordinates are forced to 0 off-screen so the painter's text index
   // always stays in range.
   assign vga.pix_tick    = pix_tick;
   assign vga.visible     = visible;
   assign vga.horzCoord   = visible ? h_cnt_q : 10'd0;
   assign vga.vertCoord   = visible ? v_cnt_q : 10'd0;
   assign vga.frame_start = frame_start_q;

`ifdef VGA_SYNC_ALIGN_EN
   // Stage 0 captures the live decode; the last stage drives the pins.
   // Blank resets low so the screen stays dark until real data arrives.
   logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
   logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
   logic [PIPE_DELAY-1:0] bl_pipe_q, bl_pipe_d;

   always_comb begin
      hs_pipe_d = PIPE_DELAY'({hs_pipe_q, hsync_raw_n});
      vs_pipe_d = PIPE_DELAY'({vs_pipe_q, vsync_raw_n});
      bl_pipe_d = PIPE_DELAY'({bl_pipe_q, visible});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
         bl_pipe_q <= '0;
      end else begin
         hs_pipe_q <= hs_pipe_d;
         vs_pipe_q <= vs_pipe_d;
         bl_pipe_q <= bl_pipe_d;
      end
   end

   assign vga.hsync_n = hs_pipe_q[PIPE_DELAY-1];
   assign vga.vsync_n = vs_pipe_q[PIPE_DELAY-1];
   assign vga.blank_n = bl_pipe_q[PIPE_DELAY-1];
`else
   assign vga.hsync_n = hsync_raw_n;
   assign vga.vsync_n = vsync_raw_n;
   assign vga.blank_n = visible;
`endif

endmodule : vga_timing

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing
//   Self-checking bench for vga_timing with a shrunken raster (30x15 pixel
//   totals, CLK_DIV=2) so full frames, wraps and resets fit in a short run.
//   The reference model derives everything from n, the number of clk edges
//   since reset was last released: pixel = n / CLK_DIV, h = pixel % H_TOTAL,
//   v = (pixel / H_TOTAL) % V_TOTAL. Sync/blank with alignment compiled in
//   are the same decode taken D cycles earlier, or the reset values while the
//   delay line is still filling.
// -----------------------------------------------------------------------------
module tb_vga_timing;

   localparam int HV = 16, HF = 4, HS = 6, HB = 4;
   localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
   localparam int DIV = 2;
   localparam int PD  = 4;
   localparam int HT  = HV + HF + HS + HB;
   localparam int VT  = VV + VF + VS + VB;
   localparam int FRAME = HT * VT * DIV;
`ifdef VGA_SYNC_ALIGN_EN
   localparam int D = PD;
`else
   localparam int D = 0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   vga_timing_if vif ();

   vga_timing #(
      .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
      .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
      .CLK_DIV   (DIV), .PIPE_DELAY (PD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .vga (vif)
   );

   int     checks   = 0;
   int     errors   = 0;
   int     n        = 0;
   longint cyc      = 0;
   longint last_fs  = -1;
   int     fs_seen  = 0;
   int     fs_model = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d, n=%0d)", tag, got, exp, cyc, n);
      end
   endtask

   // {hsync_n, vsync_n, blank_n} decoded straight from raster position m.
   function automatic logic [2:0] sync_at(input int m);
      int p, h, v;
      p = m / DIV;
      h = p % HT;
      v = (p / HT) % VT;
      return {!(h >= HV + HF && h < HV + HF + HS),
              !(v >= VV + VF && v < VV + VF + VS),
              (h < HV && v < VV)};
   endfunction

   task automatic compare_all();
      int p, h, v;
      logic vis, fs;
      logic [2:0] sy;
      p   = n / DIV;
      h   = p % HT;
      v   = (p / HT) % VT;
      vis = (h < HV) && (v < VV);
      fs  = (n > 0) && (n % FRAME == 0);
      sy  = (n >= D) ? sync_at(n - D) : 3'b110;
      if (fs) fs_model++;
      check("pix_tick",    vif.pix_tick,    32'((n % DIV) == DIV - 1));
      check("horzCoord",   vif.horzCoord,   vis ? h : 0);
      check("vertCoord",   vif.vertCoord,   vis ? v : 0);
      check("visible",     vif.visible,     32'(vis));
      check("frame_start", vif.frame_start, 32'(fs));
      check("hsync_n",     vif.hsync_n,     32'(sy[2]));
      check("vsync_n",     vif.vsync_n,     32'(sy[1]));
      check("blank_n",     vif.blank_n,     32'(sy[0]));
   endtask

   // One clk: drive rst, advance the model on the edge, sample on negedge.
   task automatic step(input logic r);
      rst = r;
      @(posedge clk);
      cyc++;
      n = r ? 0 : n + 1;
      if (r) last_fs = -1;
      @(negedge clk);
      compare_all();
      if (vif.frame_start === 1'b1) begin
         fs_seen++;
         if (last_fs >= 0) check("fs_interval", 32'(cyc - last_fs), FRAME);
         last_fs = cyc;
      end
   endtask

   initial begin
      int k, r;
      rst = 1'b1;
      @(negedge clk);

      // Cold reset held three cycles, then free-run past two frame wraps.
      repeat (3) step(1'b1);
      repeat (2 * FRAME + 40) step(1'b0);

      // Mid-frame reset at line 5, column 10, then a clean full frame.
      while ((n / DIV) % (HT * VT) != 5 * HT + 10) step(1'b0);
      step(1'b1);
      repeat (FRAME + 20) step(1'b0);

      // Reset on the very edge that would schedule frame_start.
      while (n % FRAME != FRAME - 1) step(1'b0);
      step(1'b1);
      repeat (50) step(1'b0);

      // Random run lengths and reset pulses.
      repeat (12) begin
         k = int'($urandom_range(1, 1500));
         r = int'($urandom_range(1, 3));
         repeat (k) step(1'b0);
         repeat (r) step(1'b1);
      end
      repeat (FRAME + 10) step(1'b0);

      check("fs_count", fs_seen, fs_model);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_vga_timing
